// File: rtl/mod_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : mod_id_ex_stage
// Purpose  : ID/EX pipeline register with EX-side operand forwarding, ALU
//            operand selection and load-use hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module mod_id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  // ID-stage instruction fields
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [RA_W-1:0]   id_rs_addr,
  input  logic [RA_W-1:0]   id_rt_addr,
  input  logic [RA_W-1:0]   id_rd_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [3:0]        id_alu_ctr,
  input  logic              id_alusrc_imm,
  input  logic              id_shift_imm,
  input  logic              id_reg_we,
  input  logic              id_mem_re,
  input  logic              id_mem_we,
  // Forwarding sources
  input  logic              exmem_reg_we,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_we,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  // EX-stage outputs
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctr,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [RA_W-1:0]   ex_rd,
  output logic [DATA_W-1:0] ex_pc,
  output logic              ex_valid,
  output logic              ex_reg_we,
  output logic              ex_mem_re,
  output logic              ex_mem_we,
  output logic              load_use_o
);

  localparam logic [RA_W-1:0] c_REG_ZERO = '0;

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic              r_valid;
  logic              r_reg_we;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [3:0]        r_alu_ctr;
  logic [RA_W-1:0]   r_rd;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [RA_W-1:0]   r_rs_addr;
  logic [RA_W-1:0]   r_rt_addr;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_shamt;
  logic              r_alusrc_imm;
  logic              r_shift_imm;

  // Forwarding results
  logic              w_rs_hit_exmem;
  logic              w_rs_hit_memwb;
  logic              w_rt_hit_exmem;
  logic              w_rt_hit_memwb;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // Load-use terms
  logic              w_ex_is_load;
  logic              w_rs_dep;
  logic              w_rt_dep;

  // --------------------------------------------------------------------------
  // Forward-match detection; register 0 is never a forwarding target
  // --------------------------------------------------------------------------
  assign w_rs_hit_exmem = exmem_reg_we && (exmem_rd != c_REG_ZERO) && (exmem_rd == r_rs_addr);
  assign w_rs_hit_memwb = memwb_reg_we && (memwb_rd != c_REG_ZERO) && (memwb_rd == r_rs_addr);
  assign w_rt_hit_exmem = exmem_reg_we && (exmem_rd != c_REG_ZERO) && (exmem_rd == r_rt_addr);
  assign w_rt_hit_memwb = memwb_reg_we && (memwb_rd != c_REG_ZERO) && (memwb_rd == r_rt_addr);

  // Forwarding mux: the younger EX/MEM producer takes priority over MEM/WB
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (w_rs_hit_exmem) begin
      w_fwd_rs = exmem_result;
    end else if (w_rs_hit_memwb) begin
      w_fwd_rs = memwb_data;
    end

    w_fwd_rt = r_rt_data;
    if (w_rt_hit_exmem) begin
      w_fwd_rt = exmem_result;
    end else if (w_rt_hit_memwb) begin
      w_fwd_rt = memwb_data;
    end
  end

  // --------------------------------------------------------------------------
  // ID/EX register: reset > flush > stall > load
  // --------------------------------------------------------------------------
  // Control/valid path; a flush inserts a bubble, a stall holds everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_reg_we  <= 1'b0;
      r_mem_re  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_alu_ctr <= 4'd0;
      r_rd      <= '0;
    end else if (flush_i) begin
      r_valid   <= 1'b0;
      r_reg_we  <= 1'b0;
      r_mem_re  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_alu_ctr <= 4'd0;
      r_rd      <= '0;
    end else if (!stall_i) begin
      // An invalid ID slot must not carry side effects into EX
      r_valid   <= id_valid;
      r_reg_we  <= id_valid & id_reg_we;
      r_mem_re  <= id_valid & id_mem_re;
      r_mem_we  <= id_valid & id_mem_we;
      r_alu_ctr <= id_alu_ctr;
      r_rd      <= id_rd_addr;
    end
  end

  // Operand data; during a stall it tracks the forwarded value so a producer
  // that retires mid-hold does not leave a stale register-file value behind
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs_data <= '0;
      r_rt_data <= '0;
    end else if (flush_i) begin
      r_rs_data <= '0;
      r_rt_data <= '0;
    end else if (stall_i) begin
      r_rs_data <= w_fwd_rs;
      r_rt_data <= w_fwd_rt;
    end else begin
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
    end
  end

  // Addresses, PC, immediate and operand-select flags; unaffected by flush
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= '0;
      r_rs_addr    <= '0;
      r_rt_addr    <= '0;
      r_imm        <= '0;
      r_shamt      <= 5'd0;
      r_alusrc_imm <= 1'b0;
      r_shift_imm  <= 1'b0;
    end else if (!flush_i && !stall_i) begin
      r_pc         <= id_pc;
      r_rs_addr    <= id_rs_addr;
      r_rt_addr    <= id_rt_addr;
      r_imm        <= id_imm;
      r_shamt      <= id_shamt;
      r_alusrc_imm <= id_alusrc_imm;
      r_shift_imm  <= id_shift_imm;
    end
  end

  // --------------------------------------------------------------------------
  // Operand selection
  // --------------------------------------------------------------------------
  // A comes from the shift-amount field for immediate shifts, else from rs
  always_comb begin
    alu_a = w_fwd_rs;
    if (r_shift_imm) begin
      alu_a = {{(DATA_W-5){1'b0}}, r_shamt};
    end
  end

  // B comes from the immediate for I-type ops, else from rt
  always_comb begin
    alu_b = w_fwd_rt;
    if (r_alusrc_imm) begin
      alu_b = r_imm;
    end
  end

  assign ex_store_data = w_fwd_rt;
  assign alu_ctr       = r_alu_ctr;
  assign ex_rd         = r_rd;
  assign ex_pc         = r_pc;
  assign ex_valid      = r_valid;
  assign ex_reg_we     = r_reg_we;
  assign ex_mem_re     = r_mem_re;
  assign ex_mem_we     = r_mem_we;

  // --------------------------------------------------------------------------
  // Load-use hazard: a load in EX whose result the ID instruction needs
  // --------------------------------------------------------------------------
  assign w_ex_is_load = r_valid && r_mem_re && (r_rd != c_REG_ZERO);
  assign w_rs_dep     = id_uses_rs && (r_rd == id_rs_addr);
  assign w_rt_dep     = id_uses_rt && (r_rd == id_rt_addr);
  assign load_use_o   = w_ex_is_load && (w_rs_dep || w_rt_dep);

endmodule
`default_nettype wire

// File: tb/tb_mod_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_id_ex_stage
// Purpose  : Self-checking bench for mod_id_ex_stage: vector table with a
//            scoreboard queue, plus hand sequences for reset, load-use and
//            stall/flush corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i;
  logic        id_valid;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
  logic        id_uses_rs, id_uses_rt;
  logic [3:0]  id_alu_ctr;
  logic        id_alusrc_imm, id_shift_imm;
  logic        id_reg_we, id_mem_re, id_mem_we;
  logic        exmem_reg_we, memwb_reg_we;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_data;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [3:0]  alu_ctr;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_we, ex_mem_re, ex_mem_we, load_use_o;

  int n_checks = 0;
  int n_errors = 0;

  mod_id_ex_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_ctr(id_alu_ctr),
    .id_alusrc_imm(id_alusrc_imm), .id_shift_imm(id_shift_imm),
    .id_reg_we(id_reg_we), .id_mem_re(id_mem_re), .id_mem_we(id_mem_we),
    .exmem_reg_we(exmem_reg_we), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_we(memwb_reg_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .ex_valid(ex_valid), .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re),
    .ex_mem_we(ex_mem_we), .load_use_o(load_use_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    // stimulus
    logic        valid;
    logic [31:0] pc, rs_d, rt_d, imm;
    logic [4:0]  rs_a, rt_a, rd, shamt;
    logic [3:0]  ctr;
    logic        alusrc, shift, reg_we, mem_re, mem_we;
    logic        ex_we, wb_we;
    logic [4:0]  ex_rd_f, wb_rd_f;
    logic [31:0] ex_res, wb_dat;
    // expected
    logic [31:0] e_a, e_b, e_store, e_pc;
    logic [3:0]  e_ctr;
    logic [4:0]  e_rd;
    logic        e_valid, e_reg_we, e_mem_re, e_mem_we;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t blank_vec();
    vec_t v;
    v.valid = 1'b1; v.pc = 32'h0; v.rs_d = 32'h0; v.rt_d = 32'h0; v.imm = 32'h0;
    v.rs_a = 5'd1; v.rt_a = 5'd2; v.rd = 5'd0; v.shamt = 5'd0; v.ctr = 4'd0;
    v.alusrc = 1'b0; v.shift = 1'b0; v.reg_we = 1'b0; v.mem_re = 1'b0; v.mem_we = 1'b0;
    v.ex_we = 1'b0; v.wb_we = 1'b0; v.ex_rd_f = 5'd0; v.wb_rd_f = 5'd0;
    v.ex_res = 32'h0; v.wb_dat = 32'h0;
    v.e_a = 32'h0; v.e_b = 32'h0; v.e_store = 32'h0; v.e_pc = 32'h0; v.e_ctr = 4'd0;
    v.e_rd = 5'd0; v.e_valid = 1'b1; v.e_reg_we = 1'b0; v.e_mem_re = 1'b0; v.e_mem_we = 1'b0;
    return v;
  endfunction

  // Drive one vector into ID, clock it into EX, then compare against the
  // scoreboard entry pushed when it was driven.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    id_valid = v.valid; id_pc = v.pc; id_rs_data = v.rs_d; id_rt_data = v.rt_d;
    id_imm = v.imm; id_rs_addr = v.rs_a; id_rt_addr = v.rt_a; id_rd_addr = v.rd;
    id_shamt = v.shamt; id_alu_ctr = v.ctr; id_alusrc_imm = v.alusrc;
    id_shift_imm = v.shift; id_reg_we = v.reg_we; id_mem_re = v.mem_re;
    id_mem_we = v.mem_we; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    exmem_reg_we = v.ex_we; exmem_rd = v.ex_rd_f; exmem_result = v.ex_res;
    memwb_reg_we = v.wb_we; memwb_rd = v.wb_rd_f; memwb_data = v.wb_dat;
    stall_i = 1'b0; flush_i = 1'b0;
    sb.push_back(v);
    @(posedge clk); #1;
    e = sb.pop_front();
    check($sformatf("v%0d alu_a", idx), alu_a, e.e_a);
    check($sformatf("v%0d alu_b", idx), alu_b, e.e_b);
    check($sformatf("v%0d store", idx), ex_store_data, e.e_store);
    check($sformatf("v%0d alu_ctr", idx), {28'd0, alu_ctr}, {28'd0, e.e_ctr});
    check($sformatf("v%0d ex_rd", idx), {27'd0, ex_rd}, {27'd0, e.e_rd});
    check($sformatf("v%0d ex_pc", idx), ex_pc, e.e_pc);
    check($sformatf("v%0d ctl", idx),
          {28'd0, ex_valid, ex_reg_we, ex_mem_re, ex_mem_we},
          {28'd0, e.e_valid, e.e_reg_we, e.e_mem_re, e.e_mem_we});
  endtask

  initial begin
    // ---------------- vector table ----------------
    // 0: plain load, no forwarding
    vecs[0] = blank_vec();
    vecs[0].pc = 32'h100; vecs[0].rs_d = 32'd5; vecs[0].rt_d = 32'd7; vecs[0].rd = 5'd4;
    vecs[0].ctr = 4'd1; vecs[0].reg_we = 1'b1;
    vecs[0].e_a = 32'd5; vecs[0].e_b = 32'd7; vecs[0].e_store = 32'd7; vecs[0].e_pc = 32'h100;
    vecs[0].e_ctr = 4'd1; vecs[0].e_rd = 5'd4; vecs[0].e_reg_we = 1'b1;
    // 1: rs forwarded, both stages match -> EX/MEM wins
    vecs[1] = blank_vec();
    vecs[1].pc = 32'h104; vecs[1].rs_a = 5'd3; vecs[1].rs_d = 32'h11; vecs[1].rt_d = 32'd7;
    vecs[1].rd = 5'd5; vecs[1].reg_we = 1'b1;
    vecs[1].ex_we = 1'b1; vecs[1].ex_rd_f = 5'd3; vecs[1].ex_res = 32'hAAAA;
    vecs[1].wb_we = 1'b1; vecs[1].wb_rd_f = 5'd3; vecs[1].wb_dat = 32'hBBBB;
    vecs[1].e_a = 32'hAAAA; vecs[1].e_b = 32'd7; vecs[1].e_store = 32'd7; vecs[1].e_pc = 32'h104;
    vecs[1].e_rd = 5'd5; vecs[1].e_reg_we = 1'b1;
    // 2: EX/MEM write disabled -> MEM/WB value
    vecs[2] = vecs[1];
    vecs[2].ex_we = 1'b0; vecs[2].e_a = 32'hBBBB;
    // 3: rs is register 0 -> never forwarded
    vecs[3] = vecs[1];
    vecs[3].rs_a = 5'd0; vecs[3].ex_rd_f = 5'd0; vecs[3].wb_rd_f = 5'd0; vecs[3].e_a = 32'h11;
    // 4: immediate shift, A = shamt, B = rt
    vecs[4] = blank_vec();
    vecs[4].pc = 32'h110; vecs[4].shift = 1'b1; vecs[4].shamt = 5'd4; vecs[4].rs_d = 32'h99;
    vecs[4].rt_d = 32'h10; vecs[4].ctr = 4'd7; vecs[4].rd = 5'd6; vecs[4].reg_we = 1'b1;
    vecs[4].e_a = 32'd4; vecs[4].e_b = 32'h10; vecs[4].e_store = 32'h10; vecs[4].e_pc = 32'h110;
    vecs[4].e_ctr = 4'd7; vecs[4].e_rd = 5'd6; vecs[4].e_reg_we = 1'b1;
    // 5: store: B = imm, store data = forwarded rt, A from MEM/WB
    vecs[5] = blank_vec();
    vecs[5].pc = 32'h114; vecs[5].rs_a = 5'd7; vecs[5].rs_d = 32'h1234; vecs[5].rt_a = 5'd6;
    vecs[5].rt_d = 32'h22; vecs[5].imm = 32'hFFFF_FFF0; vecs[5].alusrc = 1'b1; vecs[5].mem_we = 1'b1;
    vecs[5].ex_we = 1'b1; vecs[5].ex_rd_f = 5'd6; vecs[5].ex_res = 32'hCAFE;
    vecs[5].wb_we = 1'b1; vecs[5].wb_rd_f = 5'd7; vecs[5].wb_dat = 32'hBEEF;
    vecs[5].e_a = 32'hBEEF; vecs[5].e_b = 32'hFFFF_FFF0; vecs[5].e_store = 32'hCAFE;
    vecs[5].e_pc = 32'h114; vecs[5].e_mem_we = 1'b1;
    // 6: invalid ID slot -> control bits squashed, sltu code still captured
    vecs[6] = blank_vec();
    vecs[6].valid = 1'b0; vecs[6].pc = 32'h118; vecs[6].rs_d = 32'd3; vecs[6].rt_d = 32'd4;
    vecs[6].rd = 5'd9; vecs[6].ctr = 4'd11; vecs[6].reg_we = 1'b1; vecs[6].mem_re = 1'b1;
    vecs[6].mem_we = 1'b1;
    vecs[6].e_a = 32'd3; vecs[6].e_b = 32'd4; vecs[6].e_store = 32'd4; vecs[6].e_pc = 32'h118;
    vecs[6].e_ctr = 4'd11; vecs[6].e_rd = 5'd9; vecs[6].e_valid = 1'b0;
    // 7: write to r0 passes through as ex_rd = 0
    vecs[7] = blank_vec();
    vecs[7].pc = 32'h11C; vecs[7].rs_d = 32'h5A; vecs[7].rt_d = 32'hA5; vecs[7].ctr = 4'd2;
    vecs[7].reg_we = 1'b1;
    vecs[7].e_a = 32'h5A; vecs[7].e_b = 32'hA5; vecs[7].e_store = 32'hA5; vecs[7].e_pc = 32'h11C;
    vecs[7].e_ctr = 4'd2; vecs[7].e_reg_we = 1'b1;
    // 8: lw r8 (used by the load-use sequence)
    vecs[8] = blank_vec();
    vecs[8].pc = 32'h120; vecs[8].rs_d = 32'h40; vecs[8].imm = 32'd4; vecs[8].alusrc = 1'b1;
    vecs[8].rd = 5'd8; vecs[8].reg_we = 1'b1; vecs[8].mem_re = 1'b1;
    vecs[8].e_a = 32'h40; vecs[8].e_b = 32'd4; vecs[8].e_pc = 32'h120; vecs[8].e_rd = 5'd8;
    vecs[8].e_reg_we = 1'b1; vecs[8].e_mem_re = 1'b1;

    // ---------------- reset with arbitrary ID inputs ----------------
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    id_valid = 1'b1; id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
    id_imm = $urandom; id_rs_addr = 5'd8; id_rt_addr = 5'd8; id_rd_addr = 5'd8;
    id_shamt = 5'd3; id_alu_ctr = 4'd5; id_alusrc_imm = 1'b1; id_shift_imm = 1'b1;
    id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_reg_we = 1'b1; id_mem_re = 1'b1; id_mem_we = 1'b1;
    exmem_reg_we = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
    memwb_reg_we = 1'b0; memwb_rd = 5'd0; memwb_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst alu_a", alu_a, 32'h0);
    check("rst alu_b", alu_b, 32'h0);
    check("rst alu_ctr", {28'd0, alu_ctr}, 32'h0);
    check("rst ex_pc", ex_pc, 32'h0);
    check("rst ex_rd", {27'd0, ex_rd}, 32'h0);
    check("rst ctl", {28'd0, ex_valid, ex_reg_we, ex_mem_re, ex_mem_we}, 32'h0);
    check("rst load_use", {31'd0, load_use_o}, 32'h0);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 9; i++) apply(vecs[i], i);

    // ---------------- load-use (EX holds lw r8) ----------------
    id_rs_addr = 5'd8; id_uses_rs = 1'b1; id_rt_addr = 5'd1; id_uses_rt = 1'b0; #1;
    check("lu rs dep", {31'd0, load_use_o}, 32'd1);
    id_uses_rs = 1'b0; #1;
    check("lu rs unused", {31'd0, load_use_o}, 32'd0);
    id_rt_addr = 5'd8; id_uses_rt = 1'b1; #1;
    check("lu rt dep", {31'd0, load_use_o}, 32'd1);
    id_rt_addr = 5'd9; #1;
    check("lu rt other", {31'd0, load_use_o}, 32'd0);
    // Flush answers the hazard; a real ID instruction on the inputs must not load
    id_rt_addr = 5'd8; id_valid = 1'b1; id_reg_we = 1'b1; id_mem_re = 1'b1; id_alu_ctr = 4'd3;
    id_rd_addr = 5'd12;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("lu flush ctl", {28'd0, ex_valid, ex_reg_we, ex_mem_re, ex_mem_we}, 32'h0);
    check("lu flush ctr", {28'd0, alu_ctr}, 32'h0);
    check("lu flush rd", {27'd0, ex_rd}, 32'h0);
    check("lu flush load_use", {31'd0, load_use_o}, 32'h0);

    // ---------------- stall refresh ----------------
    id_valid = 1'b1; id_pc = 32'h200; id_rs_addr = 5'd1; id_rs_data = 32'h0;
    id_rt_addr = 5'd9; id_rt_data = 32'd1; id_rd_addr = 5'd10; id_alu_ctr = 4'd0;
    id_alusrc_imm = 1'b0; id_shift_imm = 1'b0; id_reg_we = 1'b1; id_mem_re = 1'b0;
    id_mem_we = 1'b0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    exmem_reg_we = 1'b0; memwb_reg_we = 1'b0;
    @(posedge clk); #1;
    check("sr loaded b", alu_b, 32'd1);
    memwb_reg_we = 1'b1; memwb_rd = 5'd9; memwb_data = 32'h55; stall_i = 1'b1;
    id_pc = 32'h300; id_rt_data = 32'h77; id_rd_addr = 5'd11;
    @(posedge clk); #1;
    check("sr fwd b", alu_b, 32'h55);
    memwb_reg_we = 1'b0; #1;
    check("sr refreshed b", alu_b, 32'h55);
    check("sr store", ex_store_data, 32'h55);
    @(posedge clk); #1;
    check("sr held b", alu_b, 32'h55);
    check("sr held pc", ex_pc, 32'h200);
    check("sr held rd", {27'd0, ex_rd}, 32'd10);
    check("sr held valid", {31'd0, ex_valid}, 32'd1);
    // Flush and stall together: flush wins, bubble loaded, data cleared
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; stall_i = 1'b0;
    check("fs ctl", {28'd0, ex_valid, ex_reg_we, ex_mem_re, ex_mem_we}, 32'h0);
    check("fs rd", {27'd0, ex_rd}, 32'h0);
    check("fs b", alu_b, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_id_ex_stage.md
Name: mod_id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand forwarding and operand selection.
- Directly upstream of the EX-stage ALU: produces its A, B and alu_ctr (4-bit codes 0..11: add, sub, and, or, lui, xor, nor, sll, srl, sra, slt, sltu).
- Also produces the load-use hazard flag that the hazard unit uses to stall IF/ID.

Parameters:
- DATA_W, 32, datapath width
- RA_W, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  hold the current EX contents
- flush_i  in  1  load a bubble on the next edge
- id_valid  in  1  ID holds a real instruction
- id_pc  in  32  PC of the ID instruction
- id_rs_data, id_rt_data  in  32 each  register-file read data
- id_rs_addr, id_rt_addr, id_rd_addr  in  5 each  source and destination register numbers
- id_uses_rs, id_uses_rt  in  1 each  instruction reads rs / rt
- id_imm  in  32  immediate, already extended
- id_shamt  in  5  shift amount field
- id_alu_ctr  in  4  ALU operation code
- id_alusrc_imm  in  1  B = immediate instead of rt
- id_shift_imm  in  1  A = {27'b0, shamt} instead of rs
- id_reg_we, id_mem_re, id_mem_we  in  1 each  downstream control bits
- exmem_reg_we  in  1  EX/MEM stage writes a register
- exmem_rd  in  5  EX/MEM destination register
- exmem_result  in  32  EX/MEM ALU result
- memwb_reg_we  in  1  MEM/WB stage writes a register
- memwb_rd  in  5  MEM/WB destination register
- memwb_data  in  32  MEM/WB write-back data
- alu_a, alu_b  out  32 each  ALU operands
- alu_ctr  out  4  registered ALU operation code
- ex_store_data  out  32  forwarded rt value for stores
- ex_rd  out  5  registered destination register
- ex_pc  out  32  registered PC
- ex_valid, ex_reg_we, ex_mem_re, ex_mem_we  out  1 each  registered valid and control bits
- load_use_o  out  1  load-use hazard detected

Behaviour:
- Register update priority per clk edge: rst > flush_i > stall_i > load from ID.
- rst: every registered field becomes 0, including valid, control bits, alu_ctr, rd, pc, data and imm. Outputs then read alu_a = alu_b = 0, alu_ctr = 0, load_use_o = 0.
- flush_i: valid, reg_we, mem_re, mem_we, alu_ctr, rd and data fields become 0.
- Load: every id_* field is captured. If id_valid = 0, the control bits are captured as 0 regardless of the id_* control inputs.
- Latency: ID to EX outputs is one cycle. Everything downstream of the register is combinational.
- Forwarding, evaluated separately for rs and rt:
  - If exmem_reg_we, exmem_rd != 0 and exmem_rd equals the stored address: use exmem_result.
  - Otherwise, if memwb_reg_we, memwb_rd != 0 and memwb_rd equals the stored address: use memwb_data.
  - Otherwise use the stored data.
  - EX/MEM has priority when both match.
  - Register 0 is never forwarded.
- Operand selection:
  - alu_a = {27'b0, shamt} if shift_imm, else fwd_rs.
  - alu_b = imm if alusrc_imm, else fwd_rt.
  - ex_store_data = fwd_rt always.
- Stall refresh: while stall_i = 1 and no flush, the stored rs/rt data are overwritten with the forwarded values fwd_rs/fwd_rt. This keeps a forwarded value from being lost when the producer retires during a multi-cycle hold. Addresses and control bits are held unchanged.
- load_use_o is combinational:
  - It is 1 when ex_valid, ex_mem_re and ex_rd != 0 are all true, and either (id_uses_rs and ex_rd == id_rs_addr) or (id_uses_rt and ex_rd == id_rt_addr).
  - The hazard unit answers with a flush of this block and a stall of IF/ID. This block never self-stalls.
- Simultaneous flush_i and stall_i: flush wins, and a bubble is loaded.
- Writes to register 0 from upstream pass through as ex_rd = 0. Downstream logic ignores them.

Test Plan:
- Reset: rst = 1 for 2 cycles with arbitrary id_* inputs -> all outputs 0, including load_use_o, ex_valid = 0 and alu_ctr = 0.
- Plain load: id_rs_data = 5, id_rt_data = 7, id_alu_ctr = 1, no forwarding matches -> next cycle alu_a = 5, alu_b = 7, alu_ctr = 1, ex_valid = 1.
- Forward priority:
  - Stored rs_addr = 3; exmem_rd = 3, exmem_result = 0xAAAA; memwb_rd = 3, memwb_data = 0xBBBB -> alu_a = 0xAAAA.
  - Drop exmem_reg_we -> alu_a = 0xBBBB.
  - Repeat with rs_addr = 0 -> alu_a = stored data.
- Shift and immediate: id_shift_imm = 1, id_shamt = 4, id_alusrc_imm = 0, id_rt_data = 0x10, id_alu_ctr = 7 -> alu_a = 4, alu_b = 0x10.
- Load-use:
  - EX holds lw with rd = 8 (mem_re = 1); ID has rs = 8, uses_rs = 1 -> load_use_o = 1.
  - Set uses_rs = 0 -> load_use_o = 0.
  - Then assert flush_i -> next cycle ex_valid = 0 and all control bits 0.
- Stall refresh:
  - Stored rt_addr = 9, stored data = 1; memwb_rd = 9, memwb_data = 0x55, stall_i = 1 for one cycle.
  - Next cycle memwb_reg_we = 0 with stall_i still 1 -> alu_b = 0x55 (not 1).
  - Assert flush_i and stall_i together -> bubble loaded.
